// File: rtl/mdu_iter_if.sv
// Issue/result bundle between the core FSM (master) and the iterative multiply/divide unit (slave).
interface mdu_iter_if #(parameter int WIDTH = 32);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op_valid, op, src_a, src_b,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op, src_a, src_b,
        output op_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU (shift-add) and DIV/DIVU (restoring) with HI/LO; MTHI/MTLO write in one cycle.
// Latency: done WIDTH+2 cycles after acceptance; with MDU_MUL_EARLY_OUT_EN multiplies finish in n+2 (n = multiplier bit length, min 1).
// Backpressure: op_ready only in IDLE/DONE; requests presented while busy are dropped, never queued.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    mdu_iter_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               is_div, neg_res, neg_rem;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;

    logic               accept, is_iter, op_signed, sgn_a, sgn_b;
    logic               last_iter, early;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod_fix;

    assign accept    = bus.op_valid && bus.op_ready;
    assign is_iter   = !bus.op[2];
    assign op_signed = !bus.op[0];
    assign sgn_a     = op_signed && bus.src_a[WIDTH-1];
    assign sgn_b     = op_signed && bus.src_b[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which is the correct unsigned 2^(WIDTH-1).
    assign abs_a     = sgn_a ? -bus.src_a : bus.src_a;
    assign abs_b     = sgn_b ? -bus.src_b : bus.src_b;

    // Divide: acc = {remainder, dividend/quotient}; one quotient bit per CALC cycle.
    assign quo       = acc[WIDTH-1:0];
    assign rem       = acc[2*WIDTH-1:WIDTH];
    assign div_shift = {rem, quo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mag_b};
    assign div_sub   = div_shift[WIDTH-1:0] - mag_b;

    assign prod_fix  = neg_res ? -acc : acc;

`ifdef MDU_MUL_EARLY_OUT_EN
    assign early = !is_div && (mag_b[WIDTH-1:1] == '0);
`else
    assign early = 1'b0;
`endif

    assign last_iter = (cnt == CW'(WIDTH - 1)) || early;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept && is_iter)
                    state_nxt = S_CALC;
            end
            S_CALC:  if (last_iter) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            mag_b   <= '0;
            acc     <= '0;
            mcand   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (is_iter) begin
                    is_div  <= bus.op[1];
                    neg_res <= sgn_a ^ sgn_b;
                    neg_rem <= sgn_a;
                    mag_b   <= abs_b;
                    cnt     <= '0;
                    acc     <= bus.op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                    mcand   <= {{WIDTH{1'b0}}, abs_a};
                end else if (bus.op[1:0] == 2'b00) begin
                    hi_q <= bus.src_a;
                end else if (bus.op[1:0] == 2'b01) begin
                    lo_q <= bus.src_a;
                end
            end
            case (state)
                S_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (is_div) begin
                        acc <= div_ge ? {div_sub, quo[WIDTH-2:0], 1'b1}
                                      : {div_shift[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
                    end else begin
                        if (mag_b[0])
                            acc <= acc + mcand;
                        mcand <= mcand << 1;
                        mag_b <= mag_b >> 1;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        // Divide by zero leaves rem = |dividend|, so the sign fix restores src_a in hi.
                        lo_q <= (mag_b == '0) ? '1 : (neg_res ? -quo : quo);
                        hi_q <= neg_rem ? -rem : rem;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.op_ready = (state == S_IDLE) || (state == S_DONE);
    assign bus.busy     = (state == S_CALC) || (state == S_FIX);
    assign bus.done     = (state == S_DONE);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
